fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer between the PC/IM stage and D. Owns the fetch PC and issues one
//  word request at a time to instruction memory over a req/gnt/rvalid handshake.
//  Buffers returned words in a small FIFO for D, honours D back-pressure, and
//  applies branch/jump redirects by flushing the FIFO and dropping stale responses.
// PARAMETERS
//  RESET_PC  32'h0000_3000  fetch PC loaded on reset
//  IM_BASE   32'h0000_3000  first byte address of IM
//  IM_WORDS  4096           IM size in words; valid range is [IM_BASE, IM_BASE+4*IM_WORDS)
//  BUF_DEPTH 2              FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  im_req       out  1   request valid
//  im_addr      out  32  word-aligned byte address of request
//  im_gnt       in   1   IM accepts the request this cycle
//  im_rvalid    in   1   response valid; at most one per accepted request, >=1 cycle after gnt
//  im_rdata     in   32  instruction word
//  if_valid     out  1   FIFO head valid toward D
//  if_pc        out  32  PC of head entry
//  if_instr     out  32  instruction of head entry
//  if_exc       out  1   head entry is a fetch fault (see CONFIGURATION)
//  if_ready     in   1   D consumes the head when if_valid & if_ready
//  redir_valid  in   1   redirect request
//  redir_pc     in   32  redirect target
// BEHAVIOUR
//  Reset (async): state=S_IDLE, fetch_pc=RESET_PC, FIFO empty. im_req=0, im_addr=RESET_PC,
//   if_valid=0, if_pc=0, if_instr=0, if_exc=0. Reset asserted mid-request abandons it;
//   IM is reset on the same line, so no late rvalid is expected.
//  FSM: S_IDLE -> S_REQ on the first clock after reset.
//   S_REQ:  im_req=1 iff space (count + inflight < BUF_DEPTH); im_addr=fetch_pc.
//           On im_gnt: fetch_pc += 4 (mod 2^32), latch req_pc -> S_WAIT.
//   S_WAIT: on im_rvalid push {req_pc, im_rdata, 0} -> S_REQ. The next request can issue the
//           following cycle, so best-case throughput is 1 word per 2 cycles.
//   S_DISCARD: wait for im_rvalid, drop the word -> S_REQ.
//  Redirect (highest priority), at the edge where redir_valid=1:
//   fetch_pc <= redir_pc; FIFO flushed.
//   S_REQ without gnt -> stay S_REQ. S_REQ with gnt same cycle -> S_DISCARD.
//   S_WAIT without rvalid -> S_DISCARD. S_WAIT with rvalid same cycle -> drop word, -> S_REQ.
//   S_DISCARD -> stays S_DISCARD with the new fetch_pc.
//   An if_valid&if_ready handshake in the redirect cycle still completes; all other entries vanish.
//  FIFO: push and pop in the same cycle are both performed and count is unchanged. Push when
//   full cannot occur (space gating); an assertion checks it. Outputs come from the head
//   register with zero added latency; if_* are held stable while if_valid & !if_ready.
//  Request latency: the first im_req occurs 1 cycle after reset deassertion.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//   - In S_REQ, if fetch_pc[1:0]!=0 or fetch_pc is out of the IM range, no im_req is issued.
//     When space allows, push {fetch_pc, 32'h0 (nop), exc=1}, then stop in S_REQ with im_req=0.
//   - Fetching resumes only on redirect.
//  FETCH_ALIGN_CHECK_EN undefined:
//   - im_addr = {fetch_pc[31:2], 2'b00}, no range check.
//   - if_exc is tied to 0.
// STRUCTURE
//  fetch_pkg.vh: state encodings (S_IDLE, S_REQ, S_WAIT, S_DISCARD), RESET_PC / IM_BASE
//   defaults, entry field widths {pc 32, instr 32, exc 1}.
//  Sub-module fetch_buf: synchronous FIFO with parameter DEPTH and 65-bit entry.
//   Ports: push, pop, flush, full, empty, count, head.
//  fetch_ctrl holds the FSM, fetch_pc, req_pc and the space calculation.
// TESTING
//  1 reset, IM gnt immediate, rvalid +1, if_ready=1 -> if_pc 0x3000, 0x3004, 0x3008 on
//    consecutive handshakes, one every 2 cycles.
//  2 if_ready=0 for 10 cycles -> exactly BUF_DEPTH (2) entries buffered, im_req=0;
//    release -> 0x3000, 0x3004 delivered in order, then fetch resumes at 0x3008.
//  3 redir_pc=0x3100 while in S_WAIT (rvalid 3 cycles later) -> stale word dropped;
//    next if_pc=0x3100; FIFO flushed the cycle after the redirect.
//  4 redir_valid in the same cycle as im_gnt and in the same cycle as im_rvalid ->
//    neither response reaches D; next if_pc = redir_pc.
//  5 async reset pulse mid-S_WAIT -> outputs at reset values immediately; first im_addr
//    after release is 0x3000.
//  6 FETCH_ALIGN_CHECK_EN, redir_pc=0x3002 -> if_exc=1, if_instr=0, im_req stays 0.
//    Then redir_pc=0x4000 -> fetch resumes normally.
//    Repeat with redir_pc = IM_BASE+4*IM_WORDS -> fault.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, reset defaults and the
// 65-bit {pc, instr, exc} entry carried through the fetch buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
    localparam int          IM_WORDS_DEF  = 4096;
    localparam int          BUF_DEPTH_DEF = 2;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PC_W + INSTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               exc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch entries; head is a direct register read so the
// consumer sees data with no added latency. Flush empties it in one cycle.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ENTRY_W-1:0]     push_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [ENTRY_W-1:0]     head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_q, wr_q;
    logic [PTR_W:0]     cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) rd_q <= rd_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one IM request at a time, buffers
// words for D and handles redirects. Optional FETCH_ALIGN_CHECK_EN adds fault entries.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
`ifdef FETCH_ALIGN_CHECK_EN
    parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
    parameter int          IM_WORDS  = IM_WORDS_DEF,
`endif
    parameter int          BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc,
    input  logic        if_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic               push, pop, buf_full, buf_empty, space;
    logic [CNT_W-1:0]   buf_count;
    fetch_entry_t       push_entry, head;

    // An outstanding request already owns a slot, so it counts against space.
    assign space = (32'(buf_count) + 32'(state_q == S_WAIT)) < BUF_DEPTH;
    assign pop   = if_valid & if_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;
    logic fault_q, fault_d, pc_bad;
    assign pc_bad  = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < IM_BASE) ||
                     ({1'b0, fetch_pc_q} >= IM_END);
    assign im_addr = fetch_pc_q;
`else
    assign im_addr = {fetch_pc_q[31:2], 2'b00};
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        im_req     = 1'b0;
        push       = 1'b0;
        push_entry = '{pc: req_pc_q, instr: im_rdata, exc: 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
                // A bad PC yields one fault entry, then fetch parks until redirected.
                if (pc_bad) begin
                    if (space && !fault_q) begin
                        push       = 1'b1;
                        push_entry = '{pc: fetch_pc_q, instr: 32'h0, exc: 1'b1};
                        fault_d    = 1'b1;
                    end
                end else
`endif
                begin
                    im_req = space;
                    if (space && im_gnt) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        req_pc_d   = fetch_pc_q;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: if (im_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        // Redirect wins: any response still owed by IM becomes stale.
        if (redir_valid) begin
            fetch_pc_d = redir_pc;
            push       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d    = 1'b0;
`endif
            if (state_d == S_WAIT) state_d = S_DISCARD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redir_valid),
        .push_data (push_entry),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (head)
    );

    assign if_valid = !buf_empty;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;
`ifdef FETCH_ALIGN_CHECK_EN
    assign if_exc   = head.exc;
`else
    assign if_exc   = 1'b0;
    assert property (@(posedge clk) disable iff (reset) !head.exc);
`endif

    assert property (@(posedge clk) disable iff (reset) !(push && buf_full));

endmodule
